// File: rtl/var_frame_decoder.sv
// ----------------------------------------------------------------------------
// var_frame_decoder : parses sync/cmd/len/payload frames into t_var codes
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package var_frame_decoder_pkg;
  typedef enum integer {
    var_presence = 0,
    var_0        = 1,
    var_1        = 2,
    var_2        = 3,
    var_3        = 4,
    var_rst      = 5,
    var_4        = 6,
    var_5        = 7,
    var_whatever = 8
  } t_var;
endpackage

module var_frame_decoder
  import var_frame_decoder_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int unsigned MAX_LEN   = 15,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output t_var       var_o,
  output logic       var_valid,
  input  logic       var_ready,
  output logic       err_o,
  output logic [7:0] rst_cnt
);

  localparam int unsigned    TO_W    = $clog2(TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [7:0]     LEN_MAX = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    S_HUNT = 3'd0,
    S_CMD  = 3'd1,
    S_LEN  = 3'd2,
    S_PAY  = 3'd3,
    S_EMIT = 3'd4
  } state_t;

  state_t          state_q, state_d;
  t_var            pending_q, pending_d;
  t_var            var_o_q, var_o_d;
  logic            var_valid_q, var_valid_d;
  logic            err_q, err_d;
  logic [7:0]      rst_cnt_q, rst_cnt_d;
  logic [7:0]      pay_cnt_q, pay_cnt_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            accept;

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_HUNT;
      pending_q   <= var_presence;
      var_o_q     <= var_presence;
      var_valid_q <= 1'b0;
      err_q       <= 1'b0;
      rst_cnt_q   <= 8'd0;
      pay_cnt_q   <= 8'd0;
      to_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      var_o_q     <= var_o_d;
      var_valid_q <= var_valid_d;
      err_q       <= err_d;
      rst_cnt_q   <= rst_cnt_d;
      pay_cnt_q   <= pay_cnt_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    var_o_d     = var_o_q;
    var_valid_d = var_valid_q;
    err_d       = 1'b0;
    rst_cnt_d   = rst_cnt_q;
    pay_cnt_d   = pay_cnt_q;
    to_cnt_d    = '0;

    case (state_q)
      S_HUNT: begin
        if (accept && in_data == SYNC_BYTE) state_d = S_CMD;
      end
      S_CMD: begin
        if (accept) begin
          if (in_data[3:0] <= 4'd8) begin
            pending_d = t_var'(32'(in_data[3:0]));
            state_d   = S_LEN;
          end else begin
            err_d   = 1'b1;
            state_d = S_HUNT;
          end
        end
      end
      S_LEN: begin
        if (accept) begin
          if (in_data > LEN_MAX) begin
            err_d   = 1'b1;
            state_d = S_HUNT;
          end else if (in_data == 8'd0) begin
            var_o_d     = pending_q;
            var_valid_d = 1'b1;
            state_d     = S_EMIT;
          end else begin
            pay_cnt_d = in_data;
            state_d   = S_PAY;
          end
        end
      end
      S_PAY: begin
        if (accept) begin
          pay_cnt_d = pay_cnt_q - 8'd1;
          if (pay_cnt_q == 8'd1) begin
            var_o_d     = pending_q;
            var_valid_d = 1'b1;
            state_d     = S_EMIT;
          end
        end
      end
      S_EMIT: begin
        if (var_ready) begin
          var_valid_d = 1'b0;
          state_d     = S_HUNT;
          if (var_o_q == var_rst && rst_cnt_q != 8'hFF) rst_cnt_d = rst_cnt_q + 8'd1;
        end
      end
      default: state_d = S_HUNT;
    endcase

    // Mid-frame inactivity watchdog; an accepted byte restarts it.
    if ((state_q == S_CMD || state_q == S_LEN || state_q == S_PAY) && !accept) begin
      if (to_cnt_q == TO_LAST) begin
        err_d   = 1'b1;
        state_d = S_HUNT;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    in_ready  = rst_n && (state_q != S_EMIT);
    var_o     = var_o_q;
    var_valid = var_valid_q;
    err_o     = err_q;
    rst_cnt   = rst_cnt_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_var_frame_decoder.sv
// ----------------------------------------------------------------------------
// tb_var_frame_decoder : directed frame stimulus with frame-level reference
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_var_frame_decoder;
  import var_frame_decoder_pkg::*;

  localparam logic [7:0] SYNC    = 8'hA5;
  localparam int         MAX_LEN = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  t_var       var_o;
  logic       var_valid;
  logic       var_ready = 1'b1;
  logic       err_o;
  logic [7:0] rst_cnt;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  var_frame_decoder #(
    .SYNC_BYTE(8'hA5),
    .MAX_LEN  (15),
    .TIMEOUT  (64)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .var_o    (var_o),
    .var_valid(var_valid),
    .var_ready(var_ready),
    .err_o    (err_o),
    .rst_cnt  (rst_cnt)
  );

  // Frame-level reference: expected deliveries, error count, var_rst tally
  t_var exp_q[$];
  t_var exp_v;
  t_var last_got = var_presence;
  t_var prev_var = var_presence;
  int   exp_err = 0;
  int   err_seen = 0;
  int   model_rst = 0;
  int   cyc = 0;
  int   hs_cyc[$];
  bit   mon_en = 1'b0;
  bit   prev_stall = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_en) begin
      if (rst_n) begin
        check("in_ready_vs_valid", 32'(in_ready), 32'(!var_valid));
        check("rst_cnt_model", 32'(rst_cnt), model_rst);
        if (prev_stall) begin
          check("hold_valid", 32'(var_valid), 32'd1);
          check("hold_var", var_o, prev_var);
        end
        if (err_o) err_seen++;
        if (var_valid && var_ready) begin
          hs_cyc.push_back(cyc);
          check("expected_pending", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            check("var_o", var_o, exp_v);
          end
          last_got = var_o;
          if (var_o == var_rst && model_rst < 255) model_rst++;
        end
        prev_stall = var_valid && !var_ready;
        prev_var   = var_o;
      end else begin
        model_rst  = 0;
        prev_stall = 1'b0;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("byte_accept", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Sends a frame up to the point where the decoder would reject it
  task automatic frame(input logic [7:0] cmd, input logic [7:0] len);
    send_byte(SYNC);
    send_byte(cmd);
    if (cmd[3:0] > 4'd8) begin
      exp_err++;
      return;
    end
    send_byte(len);
    if (int'(len) > MAX_LEN) begin
      exp_err++;
      return;
    end
    for (int i = 0; i < int'(len); i++)
      send_byte((i % 3 == 0) ? SYNC : 8'($urandom));
    exp_q.push_back(t_var'(32'(cmd[3:0])));
  endtask

  task automatic settle(input string tag);
    idle(4);
    check({tag, "_err_count"}, err_seen, exp_err);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int hit;
    int idx;

    idle(3);
    check("rst_in_ready_low", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_var_o", var_o, var_presence);
    check("rst_var_valid", 32'(var_valid), 32'd0);
    check("rst_rst_cnt", 32'(rst_cnt), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // Basic zero-length frame
    frame(8'h02, 8'd0);
    @(negedge clk);
    check("t2_valid_next", 32'(var_valid), 32'd1);
    check("t2_var_o", var_o, var_1);
    settle("t2");
    check("t2_last", last_got, var_1);
    check("t2_retain", var_o, var_1);

    // Downstream stall with a payload containing the sync byte
    var_ready = 1'b0;
    frame(8'h05, 8'd3);
    repeat (10) begin
      @(negedge clk);
      check("t3_stall_ready", 32'(in_ready), 32'd0);
      check("t3_stall_var", var_o, var_rst);
    end
    @(posedge clk);
    #1;
    var_ready = 1'b1;
    settle("t3");
    check("t3_rst_cnt", 32'(rst_cnt), 32'd1);

    // Bad command, then upper nibble ignored
    frame(8'h0C, 8'd0);
    settle("t4a");
    frame(8'h18, 8'd0);
    settle("t4b");
    check("t4_last", last_got, var_whatever);

    // Oversize length, then a mid-frame timeout
    frame(8'h01, 8'h10);
    settle("t5a");
    send_byte(SYNC);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h33);
    hit = 0;
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      if (err_o && hit == 0) hit = k;
    end
    exp_err++;
    check("t5_timeout_cycle", hit, 65);
    @(posedge clk);
    #1;
    settle("t5b");
    frame(8'h00, 8'd0);
    settle("t5c");
    check("t5_last", last_got, var_presence);

    // Reset mid-frame discards it silently
    send_byte(SYNC);
    send_byte(8'h03);
    send_byte(8'h02);
    send_byte(8'h44);
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_no_valid", 32'(var_valid), 32'd0);
    check("t6_no_err", 32'(err_o), 32'd0);
    check("t6_cnt_cleared", 32'(rst_cnt), 32'd0);
    @(posedge clk);
    #1;
    send_byte(8'h07);
    settle("t6a");

    // Saturation and back-to-back throughput
    idx = hs_cyc.size();
    for (int i = 0; i < 256; i++) frame(8'h05, 8'd0);
    settle("t6b");
    check("t6_rst_cnt_sat", 32'(rst_cnt), 32'd255);
    check("t6_hs_count", hs_cyc.size() - idx, 256);
    if (hs_cyc.size() > idx)
      check("t6_throughput", hs_cyc[hs_cyc.size() - 1] - hs_cyc[idx], 1020);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
